// File: rtl/alu_serial_sequencer_if.sv
// alu_serial_sequencer_if: request/result bundle for the bit-serial add/subtract sequencer.
//   master: drives start, op, a_in, b_in; samples busy, done, result, carry_out, overflow, zero.
//   slave : the sequencer side of the same signals.
interface alu_serial_sequencer_if #(parameter int WIDTH = 8);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic             zero;
   modport master (output start, op, a_in, b_in,
                   input  busy, done, result, carry_out, overflow, zero);
   modport slave  (input  start, op, a_in, b_in,
                   output busy, done, result, carry_out, overflow, zero);
endinterface

// File: rtl/alu_serial_sequencer.sv
// alu_serial_sequencer: add/subtract two WIDTH-bit operands one bit per cycle, LSB first, through a single full-adder slice.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_serial_sequencer_if.slave (start/op/a_in/b_in in; busy/done/result/carry_out/overflow/zero out)
//   Define ALU_SERIAL_FLAGS_EN to build the overflow and zero flags; otherwise both outputs are tied to 0.
module alu_serial_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   alu_serial_sequencer_if.slave  bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             op_q, op_d, c_q, c_d, cout_q, cout_d;
   logic             bb, r, cn;
   logic [WIDTH-1:0] res_sh;

   // Single full-adder slice; subtract is A + ~B + 1 with the +1 preloaded into the carry.
   assign bb     = b_q[0] ^ op_q;
   assign r      = a_q[0] ^ bb ^ c_q;
   assign cn     = (a_q[0] & bb) | (a_q[0] & c_q) | (bb & c_q);
   assign res_sh = {r, res_q[WIDTH-1:1]};

`ifdef ALU_SERIAL_FLAGS_EN
   logic ovf_q, ovf_d, zero_q, zero_d;
`endif

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      c_d     = c_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      cout_d  = cout_q;
`ifdef ALU_SERIAL_FLAGS_EN
      ovf_d   = ovf_q;
      zero_d  = zero_q;
`endif
      unique case (state_q)
         IDLE: if (bus.start) begin
            state_d = SHIFT;
            a_d     = bus.a_in;
            b_d     = bus.b_in;
            op_d    = bus.op;
            c_d     = bus.op;
            cnt_d   = '0;
         end
         SHIFT: begin
            res_d = res_sh;
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = cn;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               cout_d  = cn;
`ifdef ALU_SERIAL_FLAGS_EN
               // c_q is the carry into the MSB slice, cn the carry out of it.
               ovf_d   = c_q ^ cn;
               zero_d  = (res_sh == '0);
`endif
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= 1'b0;
         c_q     <= 1'b0;
         res_q   <= '0;
         cnt_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         c_q     <= c_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         cout_q  <= cout_d;
      end
   end

`ifdef ALU_SERIAL_FLAGS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end
   assign bus.overflow = ovf_q;
   assign bus.zero     = zero_q;
`else
   assign bus.overflow = 1'b0;
   assign bus.zero     = 1'b0;
`endif

   assign bus.busy      = (state_q == SHIFT);
   assign bus.done      = (state_q == DONE);
   assign bus.result    = res_q;
   assign bus.carry_out = cout_q;
endmodule

// File: tb/tb_alu_serial_sequencer.sv
// tb_alu_serial_sequencer: directed and random checks of alu_serial_sequencer against an arithmetic reference model.
module tb_alu_serial_sequencer;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   nchk = 0;
   int   nerr = 0;

   alu_serial_sequencer_if #(.WIDTH(W)) bus ();
   alu_serial_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

`ifdef ALU_SERIAL_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic, signed range test for overflow.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic o,
                        output logic [W-1:0] res, output logic cy, output logic ov, output logic z);
      int ua, ub, sa, sb, s;
      ua  = int'(a);
      ub  = int'(b);
      sa  = (ua >= (1 << (W-1))) ? ua - (1 << W) : ua;
      sb  = (ub >= (1 << (W-1))) ? ub - (1 << W) : ub;
      s   = o ? sa - sb : sa + sb;
      res = W'(o ? ua - ub : ua + ub);
      cy  = o ? (ua >= ub) : (ua + ub >= (1 << W));
      ov  = FLAGS && (s > (1 << (W-1)) - 1 || s < -(1 << (W-1)));
      z   = FLAGS && (res == '0);
   endtask

   // mid: SHIFT cycle (1-based) in which a stray start is pulsed, 0 for none.
   // hold: keep start high throughout and confirm a new operation begins right after DONE.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic o, input int mid, input bit hold);
      logic [W-1:0] er;
      logic ec, eo, ez;
      int edges, dones;
      model(a, b, o, er, ec, eo, ez);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a_in  = a;
      bus.b_in  = b;
      bus.op    = o;
      @(negedge clk);
      edges     = 1;
      bus.a_in  = W'($urandom);
      bus.b_in  = W'($urandom);
      bus.op    = 1'($urandom);
      chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
      while (bus.done !== 1'b1 && edges < 4 * W) begin
         bus.start = hold || (edges == mid);
         if (edges == mid) begin
            bus.a_in = 1;
            bus.b_in = 1;
         end
         @(negedge clk);
         edges++;
      end
      chk({tag, ".latency"}, 32'(edges), 32'(W + 1));
      chk({tag, ".result"}, 32'(bus.result), 32'(er));
      chk({tag, ".carry"}, 32'(bus.carry_out), 32'(ec));
      chk({tag, ".overflow"}, 32'(bus.overflow), 32'(eo));
      chk({tag, ".zero"}, 32'(bus.zero), 32'(ez));
      chk({tag, ".busy_in_done"}, 32'(bus.busy), 32'd0);
      @(negedge clk);
      chk({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
      chk({tag, ".hold_result"}, 32'(bus.result), 32'(er));
      if (hold) begin
         @(negedge clk);
         chk({tag, ".restart"}, 32'(bus.busy), 32'd1);
         bus.start = 1'b0;
         dones = 0;
         while (bus.done !== 1'b1 && dones < 4 * W) begin
            @(negedge clk);
            dones++;
         end
         chk({tag, ".drain"}, 32'(bus.done), 32'd1);
         @(negedge clk);
      end
      bus.start = 1'b0;
   endtask

   initial begin
      int seen;
      bus.start = 1'b0;
      bus.op    = 1'b0;
      bus.a_in  = '0;
      bus.b_in  = '0;
      #12;
      chk("rst.busy", 32'(bus.busy), 32'd0);
      chk("rst.done", 32'(bus.done), 32'd0);
      chk("rst.result", 32'(bus.result), 32'd0);
      chk("rst.flags", {29'd0, bus.carry_out, bus.overflow, bus.zero}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("add", 8'h25, 8'h1A, 1'b0, 0, 1'b0);
      run_op("wrap", 8'hFF, 8'h01, 1'b0, 0, 1'b0);
      run_op("sovf", 8'h7F, 8'h01, 1'b0, 0, 1'b0);
      run_op("sub_borrow", 8'h05, 8'h07, 1'b1, 0, 1'b0);
      run_op("sub_zero", 8'h10, 8'h10, 1'b1, 0, 1'b0);
      run_op("start_busy", 8'h3C, 8'h55, 1'b0, 3, 1'b0);
      run_op("start_hold", 8'h80, 8'h01, 1'b1, 0, 1'b1);
      // Reset during SHIFT cycle 4.
      @(negedge clk);
      bus.start = 1'b1;
      bus.a_in  = 8'h5A;
      bus.b_in  = 8'h33;
      bus.op    = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst.busy", 32'(bus.busy), 32'd0);
      chk("midrst.result", 32'(bus.result), 32'd0);
      chk("midrst.flags", {29'd0, bus.carry_out, bus.overflow, bus.zero}, 32'd0);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      chk("midrst.no_done", 32'(seen), 32'd0);
      rst_n = 1'b1;
      run_op("after_rst", 8'h03, 8'h04, 1'b0, 0, 1'b0);
      for (int i = 0; i < 20; i++)
         run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 0, 1'b0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
